// File: rtl/nibble_serial_adder_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
//   state_t         : FSM state encoding (IDLE -> RUN -> DONE -> IDLE)
//   DEFAULT_NIBBLES : default operand width in nibbles
package nibble_serial_adder_seq_pkg;

   localparam int unsigned DEFAULT_NIBBLES = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_seq_shift_reg.sv
// nibble_shift_reg: W-bit register with synchronous load and 4-bit right shift.
// shift_in enters at the top nibble; the bottom nibble is shifted out.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears q
//   load     : load load_val (has priority over shift)
//   load_val : parallel load value
//   shift    : shift right by one nibble
//   shift_in : nibble entering at q[W-1:W-4]
//   q        : register contents
module nibble_shift_reg #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift,
   input  logic [3:0]   shift_in,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= {shift_in, q[W-1:4]};
      end
   end

endmodule

// File: rtl/nibble_serial_adder_seq.sv
// nibble_serial_adder_seq: drives an external combinational 4-bit adder one
// nibble per clock (LSB first) to add or subtract W = 4*NIBBLES-bit operands.
//   clk_i, rst_i       : clock (rising edge), synchronous active-high reset
//   start_i, sub_i     : request an operation (sampled in IDLE), 1 = A-B
//   a_i, b_i           : operands, sampled with start_i
//   carry_i            : extra carry-in (only with NIBBLE_SERIAL_CARRY_IN_EN)
//   add_a_o/b_o/ci_o   : operand nibbles and carry to the adder (0 unless RUN)
//   add_s_i, add_co_i  : adder sum nibble and carry out
//   busy_o             : high while in RUN
//   done_o             : one-cycle pulse, result valid
//   sum_o, carry_o     : result and final carry (subtract: 1 = no borrow)
//   ovf_o, zero_o      : signed overflow, result == 0
// Build option: define NIBBLE_SERIAL_CARRY_IN_EN to add carry_i for ADC/SBB chaining.
module nibble_serial_adder_seq
   import nibble_serial_adder_seq_pkg::*;
#(
   parameter int unsigned NIBBLES = DEFAULT_NIBBLES
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 sub_i,
   input  logic [4*NIBBLES-1:0] a_i,
   input  logic [4*NIBBLES-1:0] b_i,
`ifdef NIBBLE_SERIAL_CARRY_IN_EN
   input  logic                 carry_i,
`endif
   output logic [3:0]           add_a_o,
   output logic [3:0]           add_b_o,
   output logic                 add_ci_o,
   input  logic [3:0]           add_s_i,
   input  logic                 add_co_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [4*NIBBLES-1:0] sum_o,
   output logic                 carry_o,
   output logic                 ovf_o,
   output logic                 zero_o
);

   localparam int unsigned W = 4 * NIBBLES;

   state_t         state;
   logic [3:0]     cnt;
   logic           c;
   logic           a_sign;
   logic           b_sign;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   res_q;
   logic [W-1:0]   b_ld;
   logic [W-1:0]   res_next;
   logic           c_init;
   logic           load_en;
   logic           shift_en;
   logic           last;
   logic           unused_bits;

   assign b_ld     = sub_i ? ~b_i : b_i;
`ifdef NIBBLE_SERIAL_CARRY_IN_EN
   assign c_init   = sub_i ^ carry_i;
`else
   assign c_init   = sub_i;
`endif
   assign load_en  = (state == ST_IDLE) && start_i;
   assign shift_en = (state == ST_RUN);
   assign last     = (cnt == 4'(NIBBLES - 1));

   // Result as it will stand after the current RUN edge; used on the last
   // nibble so sum_o and the flags are valid in the same cycle as done_o.
   assign res_next = {add_s_i, res_q[W-1:4]};

   assign add_a_o  = shift_en ? a_q[3:0] : '0;
   assign add_b_o  = shift_en ? b_q[3:0] : '0;
   assign add_ci_o = shift_en ? c : 1'b0;

   assign unused_bits = ^{a_q[W-1:4], b_q[W-1:4], res_q[3:0]};

   nibble_shift_reg #(.W(W)) u_a_sh (
      .clk      (clk_i),
      .rst      (rst_i),
      .load     (load_en),
      .load_val (a_i),
      .shift    (shift_en),
      .shift_in (4'h0),
      .q        (a_q)
   );

   nibble_shift_reg #(.W(W)) u_b_sh (
      .clk      (clk_i),
      .rst      (rst_i),
      .load     (load_en),
      .load_val (b_ld),
      .shift    (shift_en),
      .shift_in (4'h0),
      .q        (b_q)
   );

   nibble_shift_reg #(.W(W)) u_res_sh (
      .clk      (clk_i),
      .rst      (rst_i),
      .load     (load_en),
      .load_val ({W{1'b0}}),
      .shift    (shift_en),
      .shift_in (add_s_i),
      .q        (res_q)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         c       <= 1'b0;
         a_sign  <= 1'b0;
         b_sign  <= 1'b0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         sum_o   <= '0;
         carry_o <= 1'b0;
         ovf_o   <= 1'b0;
         zero_o  <= 1'b1;
      end else begin
         done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  c      <= c_init;
                  cnt    <= '0;
                  a_sign <= a_i[W-1];
                  b_sign <= b_ld[W-1];
                  busy_o <= 1'b1;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               c   <= add_co_i;
               cnt <= cnt + 4'd1;
               if (last) begin
                  // Final carry is the adder's carry out of the top nibble.
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
                  sum_o   <= res_next;
                  carry_o <= add_co_i;
                  zero_o  <= (res_next == '0);
                  ovf_o   <= (a_sign == b_sign) && (res_next[W-1] != a_sign);
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// Self-checking bench for nibble_serial_adder_seq (NIBBLES=4) with a
// behavioural 4-bit adder (A + B + Ci -> {Co, S}) wired in the loop.
module tb_nibble_serial_adder_seq;

   localparam int unsigned N = 4;
   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carry_in;
   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_ci;
   logic [3:0]   add_s;
   logic         add_co;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry;
   logic         ovf;
   logic         zero;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] prev_sum;

   always #5 clk = ~clk;

   assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};

   nibble_serial_adder_seq #(.NIBBLES(N)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .sub_i    (sub),
      .a_i      (a),
      .b_i      (b),
`ifdef NIBBLE_SERIAL_CARRY_IN_EN
      .carry_i  (carry_in),
`endif
      .add_a_o  (add_a),
      .add_b_o  (add_b),
      .add_ci_o (add_ci),
      .add_s_i  (add_s),
      .add_co_i (add_co),
      .busy_o   (busy),
      .done_o   (done),
      .sum_o    (sum),
      .carry_o  (carry),
      .ovf_o    (ovf),
      .zero_o   (zero)
   );

   typedef struct {
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      logic         c;
      logic         o;
      logic         z;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Issue one operation from IDLE and check every cycle through DONE.
   task automatic run_op(input logic s, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] es, input logic ec, input logic eo, input logic ez);
      logic [W-1:0] bx;
      bx = s ? ~vb : vb;
      @(negedge clk);
      start = 1'b1; sub = s; a = va; b = vb;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= N; k++) begin
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         chk("sum_hold", sum, prev_sum);
         if (k == 1) begin
            chk("add_ci_first", add_ci, s);
            chk("add_a_first", add_a, va[3:0]);
            chk("add_b_first", add_b, bx[3:0]);
         end
         @(negedge clk);
      end
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("sum", sum, es);
      chk("carry", carry, ec);
      chk("ovf", ovf, eo);
      chk("zero", zero, ez);
      prev_sum = es;
   endtask

   initial begin
      vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; carry_in = 1'b0;
      prev_sum = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_zero", zero, 1);
      chk("rst_carry", carry, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_ci", add_ci, 0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].c, vecs[i].o, vecs[i].z);

      // start held high through RUN with a changing a_i: one result, first operands.
      @(negedge clk);
      start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222;
      for (int k = 1; k <= N + 1; k++) begin
         @(negedge clk);
         a = 16'($urandom);
         chk("held_done", done, (k == N + 1) ? 1 : 0);
         chk("held_busy", busy, (k <= N) ? 1 : 0);
      end
      chk("held_sum", sum, 16'h3333);
      start = 1'b0;
      prev_sum = 16'h3333;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("held_idle_busy", busy, 0);
         chk("held_idle_done", done, 0);
      end

      // Reset during the second RUN cycle.
      @(negedge clk);
      start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h0FCD;
      @(negedge clk);
      start = 1'b0;
      chk("abort_busy_pre", busy, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_sum", sum, 0);
      chk("abort_zero", zero, 1);
      chk("abort_done", done, 0);
      chk("abort_add_a", add_a, 0);
      for (int k = 0; k < N + 2; k++) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
         chk("abort_no_busy", busy, 0);
      end
      prev_sum = '0;

`ifdef NIBBLE_SERIAL_CARRY_IN_EN
      carry_in = 1'b1;
      run_op(1'b0, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0, 1'b0);
      carry_in = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
